// File: rtl/jogador_automatico.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : jogador_automatico
// Function : Automatic Genius player. It records the flashes shown on leds
//            and replays them as timed presses on botoes.
// Option   : ERRO_PROPOSITAL_EN adds forcar_erro, which corrupts the last press.
// Revision : 1.0 - initial release
// ============================================================================
module jogador_automatico #(
    parameter int DEPTH        = 16,
    parameter int PRESS_CYCLES = 100,
    parameter int GAP_CYCLES   = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] leds,
    input  logic       captura,
    input  logic       jogar,
    input  logic       abortar,
`ifdef ERRO_PROPOSITAL_EN
    input  logic       forcar_erro,
`endif
    output logic [3:0] botoes,
    output logic       ocupado,
    output logic       pronto,
    output logic [4:0] n_gravados,
    output logic       cheio,
    output logic       led_invalido
);

    localparam int c_TMAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int c_TW   = $clog2(c_TMAX + 1);
    localparam int c_AW   = $clog2(DEPTH);
    localparam logic [c_TW-1:0] c_PRESS_LAST = c_TW'(PRESS_CYCLES - 1);
    localparam logic [c_TW-1:0] c_GAP_LAST   = c_TW'(GAP_CYCLES - 1);
    localparam logic [4:0]      c_DEPTH      = 5'(DEPTH);

    typedef enum logic [1:0] {
        S_OCIOSO    = 2'd0,
        S_PRESSIONA = 2'd1,
        S_SOLTA     = 2'd2,
        S_FIM       = 2'd3
    } state_t;

    state_t          r_state;
    logic [3:0]      r_buf [DEPTH];
    logic            r_aceso_d;
    logic            r_captura_d;
    logic [4:0]      r_n;
    logic [4:0]      r_rd;
    logic [c_TW-1:0] r_timer;
    logic            r_cheio;
    logic            r_inv;
    logic [3:0]      r_botoes;
    logic            r_pronto;
`ifdef ERRO_PROPOSITAL_EN
    logic            r_erro;
`endif

    logic       w_aceso;
    logic       w_flash;
    logic       w_cap_rise;
    logic       w_onehot;
    logic       w_idle;
    logic [4:0] w_base;
    logic       w_store;
    logic [4:0] w_rd_next;
    logic [3:0] w_first_val;
    logic [3:0] w_next_val;

    assign w_aceso    = |leds;
    assign w_flash    = w_aceso & ~r_aceso_d;
    assign w_cap_rise = captura & ~r_captura_d;
    assign w_onehot   = w_aceso && ((leds & (leds - 4'd1)) == 4'd0);
    assign w_idle     = (r_state == S_OCIOSO) && !abortar;
    // A captura rising edge clears the count first, so a coincident flash lands at index 0.
    assign w_base     = w_cap_rise ? 5'd0 : r_n;
    assign w_store    = w_idle && captura && w_flash && (w_base < c_DEPTH);
    assign w_rd_next  = r_rd + 5'd1;

    always_comb begin
        w_first_val = r_buf[0];
        w_next_val  = r_buf[w_rd_next[c_AW-1:0]];
`ifdef ERRO_PROPOSITAL_EN
        if (forcar_erro && (r_n == 5'd1))
            w_first_val = {w_first_val[2:0], w_first_val[3]};
        if (r_erro && (w_rd_next == r_n - 5'd1))
            w_next_val = {w_next_val[2:0], w_next_val[3]};
`endif
    end

    always_ff @(posedge clock) begin
        if (w_store)
            r_buf[w_base[c_AW-1:0]] <= leds;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_aceso_d   <= 1'b0;
            r_captura_d <= 1'b0;
            r_n         <= 5'd0;
            r_cheio     <= 1'b0;
            r_inv       <= 1'b0;
        end else begin
            r_aceso_d   <= w_aceso;
            r_captura_d <= captura;
            if (w_idle) begin
                if (w_cap_rise) begin
                    r_n     <= 5'd0;
                    r_cheio <= 1'b0;
                    r_inv   <= 1'b0;
                end
                if (captura && w_flash) begin
                    if (w_base < c_DEPTH) begin
                        r_n <= w_base + 5'd1;
                        if (!w_onehot)
                            r_inv <= 1'b1;
                    end else begin
                        r_cheio <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_OCIOSO;
            r_botoes <= 4'd0;
            r_pronto <= 1'b0;
            r_rd     <= 5'd0;
            r_timer  <= '0;
`ifdef ERRO_PROPOSITAL_EN
            r_erro   <= 1'b0;
`endif
        end else if (abortar) begin
            r_state  <= S_OCIOSO;
            r_botoes <= 4'd0;
            r_pronto <= 1'b0;
            r_timer  <= '0;
        end else begin
            case (r_state)
                S_OCIOSO: begin
                    r_pronto <= 1'b0;
                    if (jogar) begin
                        if (r_n != 5'd0) begin
                            r_state  <= S_PRESSIONA;
                            r_rd     <= 5'd0;
                            r_botoes <= w_first_val;
                            r_timer  <= '0;
`ifdef ERRO_PROPOSITAL_EN
                            r_erro   <= forcar_erro;
`endif
                        end else begin
                            r_state  <= S_FIM;
                            r_pronto <= 1'b1;
                        end
                    end
                end
                S_PRESSIONA: begin
                    if (r_timer == c_PRESS_LAST) begin
                        r_state  <= S_SOLTA;
                        r_botoes <= 4'd0;
                        r_timer  <= '0;
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                S_SOLTA: begin
                    if (r_timer == c_GAP_LAST) begin
                        r_rd    <= w_rd_next;
                        r_timer <= '0;
                        if (w_rd_next == r_n) begin
                            r_state  <= S_FIM;
                            r_pronto <= 1'b1;
                        end else begin
                            r_state  <= S_PRESSIONA;
                            r_botoes <= w_next_val;
                        end
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                S_FIM: begin
                    r_pronto <= 1'b0;
                    r_state  <= S_OCIOSO;
                end
                default: begin
                    r_state  <= S_OCIOSO;
                    r_botoes <= 4'd0;
                    r_pronto <= 1'b0;
                end
            endcase
        end
    end

    assign botoes       = r_botoes;
    assign ocupado      = (r_state != S_OCIOSO);
    assign pronto       = r_pronto;
    assign n_gravados   = r_n;
    assign cheio        = r_cheio;
    assign led_invalido = r_inv;

endmodule
`default_nettype wire

// File: tb/tb_jogador_automatico.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_jogador_automatico
// Function : Randomized self-checking bench for jogador_automatico.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jogador_automatico;

    localparam int DEPTH = 16;
    localparam int PRESS = 3;
    localparam int GAP   = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] leds = 4'd0;
    logic       captura = 1'b0;
    logic       jogar = 1'b0;
    logic       abortar = 1'b0;
    logic       forcar_erro = 1'b0;
    logic [3:0] botoes;
    logic       ocupado;
    logic       pronto;
    logic [4:0] n_gravados;
    logic       cheio;
    logic       led_invalido;

    int checks = 0;
    int failures = 0;

    // Reference model: the recorded sequence plus the sticky flags.
    logic [3:0] q[$];
    bit         m_cheio;
    bit         m_inv;

    jogador_automatico #(
        .DEPTH(DEPTH),
        .PRESS_CYCLES(PRESS),
        .GAP_CYCLES(GAP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .leds(leds),
        .captura(captura),
        .jogar(jogar),
        .abortar(abortar),
`ifdef ERRO_PROPOSITAL_EN
        .forcar_erro(forcar_erro),
`endif
        .botoes(botoes),
        .ocupado(ocupado),
        .pronto(pronto),
        .n_gravados(n_gravados),
        .cheio(cheio),
        .led_invalido(led_invalido)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] rand_onehot();
        logic [3:0] v;
        v = 4'b0001 << $urandom_range(3, 0);
        return v;
    endfunction

    task automatic arm();
        captura = 1'b0;
        step();
        captura = 1'b1;
        q.delete();
        m_cheio = 1'b0;
        m_inv = 1'b0;
        step();
    endtask

    task automatic flash(input logic [3:0] v);
        leds = v;
        step();
        step();
        leds = 4'd0;
        step();
        if (q.size() < DEPTH) begin
            q.push_back(v);
            if ($countones(v) != 1) m_inv = 1'b1;
        end else begin
            m_cheio = 1'b1;
        end
    endtask

    task automatic end_capture(input string tag);
        captura = 1'b0;
        step();
        checks++;
        if (n_gravados !== 5'(q.size())) begin
            failures++;
            $display("FAIL %s_n_gravados got=%0d exp=%0d", tag, n_gravados, q.size());
        end
        checks++;
        if (cheio !== m_cheio) begin
            failures++;
            $display("FAIL %s_cheio got=%b exp=%b", tag, cheio, m_cheio);
        end
        checks++;
        if (led_invalido !== m_inv) begin
            failures++;
            $display("FAIL %s_led_invalido got=%b exp=%b", tag, led_invalido, m_inv);
        end
    endtask

    // Pulses jogar and follows the whole replay cycle by cycle: {botoes,ocupado,pronto}.
    task automatic play_and_watch(input string tag, input bit erro);
        logic [3:0] exp_seq[$];
        logic [3:0] v;
        exp_seq = q;
        if (erro && exp_seq.size() > 0) begin
            v = exp_seq[exp_seq.size()-1];
            exp_seq[exp_seq.size()-1] = {v[2:0], v[3]};
        end
        forcar_erro = erro;
        jogar = 1'b1;
        step();
        jogar = 1'b0;
        forcar_erro = 1'b0;
        for (int i = 0; i < exp_seq.size(); i++) begin
            for (int p = 0; p < PRESS; p++) begin
                checks++;
                if ({botoes, ocupado, pronto} !== {exp_seq[i], 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL %s_press[%0d].%0d got=%b exp=%b", tag, i, p,
                             {botoes, ocupado, pronto}, {exp_seq[i], 1'b1, 1'b0});
                end
                step();
            end
            for (int g = 0; g < GAP; g++) begin
                checks++;
                if ({botoes, ocupado, pronto} !== 6'b0000_10) begin
                    failures++;
                    $display("FAIL %s_gap[%0d].%0d got=%b exp=%b", tag, i, g,
                             {botoes, ocupado, pronto}, 6'b0000_10);
                end
                step();
            end
        end
        checks++;
        if ({botoes, ocupado, pronto} !== 6'b0000_11) begin
            failures++;
            $display("FAIL %s_pronto got=%b exp=%b", tag, {botoes, ocupado, pronto}, 6'b0000_11);
        end
        step();
        checks++;
        if ({botoes, ocupado, pronto} !== 6'b0000_00) begin
            failures++;
            $display("FAIL %s_after got=%b exp=%b", tag, {botoes, ocupado, pronto}, 6'b0000_00);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        checks++;
        if ({botoes, ocupado, pronto, n_gravados, cheio, led_invalido} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {botoes, ocupado, pronto, n_gravados, cheio, led_invalido}, 13'd0);
        end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_capture_replay();
        arm();
        flash(4'b0001);
        flash(4'b0100);
        flash(4'b0010);
        end_capture("plan");
        play_and_watch("plan", 1'b0);
    endtask

    task automatic test_random_replay();
        for (int it = 0; it < 3; it++) begin
            arm();
            for (int k = 0; k < int'($urandom_range(6, 1)); k++) begin
                flash(rand_onehot());
                repeat ($urandom_range(3, 0)) step();
            end
            end_capture("rand");
            play_and_watch("rand", 1'b0);
        end
    endtask

    task automatic test_full();
        arm();
        for (int k = 0; k < DEPTH + 1; k++) flash(rand_onehot());
        end_capture("full");
        captura = 1'b1;
        leds = 4'b1000;
        q.delete();
        q.push_back(4'b1000);
        m_cheio = 1'b0;
        m_inv = 1'b0;
        step();
        step();
        leds = 4'd0;
        step();
        end_capture("rearm_flash");
        play_and_watch("rearm_flash", 1'b0);
    endtask

    task automatic test_invalid_and_empty();
        arm();
        flash(rand_onehot());
        flash(4'b0011);
        end_capture("invalid");
        play_and_watch("invalid", 1'b0);
        arm();
        end_capture("empty");
        play_and_watch("empty", 1'b0);
    endtask

    task automatic test_abort();
        arm();
        flash(4'b0001);
        flash(4'b0100);
        flash(4'b0010);
        end_capture("abort");
        jogar = 1'b1;
        step();
        jogar = 1'b0;
        repeat (PRESS + GAP + 1) step();
        checks++;
        if (botoes !== 4'b0100) begin
            failures++;
            $display("FAIL abort_second_press got=%b exp=%b", botoes, 4'b0100);
        end
        abortar = 1'b1;
        step();
        abortar = 1'b0;
        checks++;
        if ({botoes, ocupado, pronto} !== 6'd0) begin
            failures++;
            $display("FAIL abort_outputs got=%b exp=%b", {botoes, ocupado, pronto}, 6'd0);
        end
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (pronto !== 1'b0 || ocupado !== 1'b0) begin
                failures++;
                $display("FAIL abort_quiet[%0d] got=%b exp=%b", c, {ocupado, pronto}, 2'b00);
            end
            step();
        end
        abortar = 1'b1;
        jogar = 1'b1;
        step();
        abortar = 1'b0;
        jogar = 1'b0;
        checks++;
        if ({botoes, ocupado, pronto} !== 6'd0) begin
            failures++;
            $display("FAIL abort_vs_jogar got=%b exp=%b", {botoes, ocupado, pronto}, 6'd0);
        end
        play_and_watch("after_abort", 1'b0);
    endtask

`ifdef ERRO_PROPOSITAL_EN
    task automatic test_erro();
        arm();
        flash(4'b0001);
        flash(4'b1000);
        end_capture("erro");
        play_and_watch("erro", 1'b1);
        play_and_watch("erro_off", 1'b0);
    endtask
`endif

    task automatic test_reset_mid();
        arm();
        flash(4'b0100);
        flash(4'b0001);
        end_capture("mid");
        jogar = 1'b1;
        step();
        jogar = 1'b0;
        step();
        checks++;
        if (botoes !== 4'b0100) begin
            failures++;
            $display("FAIL mid_pressing got=%b exp=%b", botoes, 4'b0100);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({botoes, ocupado, pronto, n_gravados, cheio, led_invalido} !== 13'd0) begin
            failures++;
            $display("FAIL mid_async_reset got=%b exp=%b",
                     {botoes, ocupado, pronto, n_gravados, cheio, led_invalido}, 13'd0);
        end
        q.delete();
        m_cheio = 1'b0;
        m_inv = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_capture_replay();
        test_random_replay();
        test_full();
        test_invalid_and_empty();
        test_abort();
`ifdef ERRO_PROPOSITAL_EN
        test_erro();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jogador_automatico.md
Name: jogador_automatico

Overview:
- Automatic player for the Genius game: the other end of the LED/button interface of the game datapath.
- Watches the game's `leds` output while the sequence is shown, records each flash into an internal 16x4 buffer, then replays the recorded sequence on `botoes` as timed button presses.
- Sits outside the game datapath. Its `botoes` drives the datapath button input; its `leds` input taps the datapath LED output.
- Used for self-play demos and for regression benches of the game.

Parameters:
- DEPTH, 16: buffer entries; also the maximum sequence length.
- PRESS_CYCLES, 100: clock cycles each button is held high (must be ≥1).
- GAP_CYCLES, 100: clock cycles of `botoes`=0 between presses (must be ≥1).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- leds  in  4  game LED output, one-hot while lit, 0 while dark.
- captura  in  1  level; high while the game is showing the sequence.
- jogar  in  1  single-cycle pulse; starts replay.
- abortar  in  1  synchronous abort; overrides everything except reset.
- botoes  out  4  button drive to the game, one-hot or 0.
- ocupado  out  1  high in any state other than OCIOSO.
- pronto  out  1  single-cycle pulse when a replay completes.
- n_gravados  out  5  number of flashes currently stored (0..16).
- cheio  out  1  buffer full; more flashes were seen than could be stored.
- led_invalido  out  1  sticky; a stored flash was not one-hot.

Behaviour:
- Reset (reset=0, async):
  - state OCIOSO.
  - botoes=0, pronto=0, ocupado=0, n_gravados=0, cheio=0, led_invalido=0.
  - Read pointer and timers = 0. Buffer contents are don't-care.
- Flash detection:
  - `aceso` = (leds != 0), registered into `aceso_d`.
  - A flash is the cycle where aceso=1 and aceso_d=0.
- Capture (OCIOSO only):
  - On a captura rising edge (captura=1, captura_d=0): n_gravados←0, cheio←0, led_invalido←0.
  - On a flash while captura=1 and n_gravados<DEPTH: buffer[n_gravados]←leds, n_gravados++.
  - If leds is not one-hot on that flash: led_invalido←1. The value is still stored.
  - On a flash when n_gravados==DEPTH: nothing stored, cheio←1.
  - Captura rising edge and a flash in the same cycle: the clear applies first, then leds is stored at index 0, so n_gravados=1.
  - Outside OCIOSO, captura and leds are ignored, and captura_d/aceso_d still track their inputs.
- FSM states: OCIOSO, PRESSIONA, SOLTA, FIM.
- OCIOSO → PRESSIONA:
  - Taken on jogar=1 with n_gravados>0.
  - rd←0. botoes←buffer[0] at the same edge, so botoes is valid from the cycle after jogar (1-cycle latency).
  - Timer←0.
- OCIOSO → FIM: taken on jogar=1 with n_gravados=0.
- PRESSIONA:
  - botoes holds buffer[rd] for exactly PRESS_CYCLES cycles.
  - Then → SOLTA with botoes←0 and timer←0.
- SOLTA:
  - botoes=0 for exactly GAP_CYCLES cycles, then rd++.
  - If the new rd==n_gravados → FIM.
  - Otherwise → PRESSIONA with botoes←buffer[rd].
- FIM: pronto=1 for exactly one cycle, then → OCIOSO.
- jogar is ignored outside OCIOSO.
- abortar=1 in any state:
  - Next state OCIOSO, botoes=0, no pronto pulse.
  - Buffer and n_gravados are kept, so an immediate re-jogar replays from index 0.
  - abortar and jogar in the same cycle: abortar wins and the FSM stays in OCIOSO.
- Timers are sized clog2(max(PRESS_CYCLES, GAP_CYCLES)+1) bits. The read pointer is 5 bits wide.
- Reset mid-replay: botoes drops to 0 immediately (asynchronously).

Optional Feature:
- Macro: ERRO_PROPOSITAL_EN.
- Defined:
  - Adds input `forcar_erro` (1 bit), sampled on the accepted jogar edge and held for that replay.
  - When held set, the press at index n_gravados−1 drives {b[2:0],b[3]} (rotate-left of the stored value) instead of the stored value.
  - This exercises the game's wrong-play path.
- Undefined: no `forcar_erro` port; every press is the stored value.

Test Plan (PRESS_CYCLES=3, GAP_CYCLES=2):
1. Reset, captura=1, flashes 0001, 0100, 0010, captura=0 → n_gravados=3, cheio=0, led_invalido=0.
2. Then jogar pulse at edge k → botoes=0001 for k+1..k+3, 0 for k+4..k+5, 0100 for k+6..k+8, 0 for k+9..k+10, 0010 for k+11..k+13, 0 for k+14..k+15, pronto=1 at k+16 only, ocupado=0 afterwards.
3. Capture 17 flashes → n_gravados=16, cheio=1. A new captura rising edge with a flash 1000 in the same cycle → n_gravados=1, cheio=0, buffer[0]=1000.
4. Flash with leds=0011 → led_invalido=1, n_gravados increments. jogar with n_gravados=0 after a captura re-arm → pronto the cycle after jogar, botoes stays 0.
5. abortar during the second press of scenario 2 → botoes=0 next cycle, ocupado=0, no pronto. A following jogar restarts from 0001.
6. With ERRO_PROPOSITAL_EN, forcar_erro=1, sequence 0001, 1000 → presses 0001 then 0001 (rotated 1000). Async reset mid-press → botoes=0 and all outputs at reset values immediately.
